// File: rtl/tdm_demux_1to4_pkg.sv
// rtl/tdm_demux_1to4_pkg.sv - shared types and frame constants for the TDM demux
// TDM_PARITY_CHK_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = 2;

`ifdef TDM_PARITY_CHK_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif

    localparam int DEF_FRAME_LEN = DEF_NUM_CH + PAR_SLOTS;

    function automatic int frame_len(input int num_ch);
        return num_ch + PAR_SLOTS;
    endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// rtl/tdm_demux_1to4_if.sv - serial slot stream in, recovered parallel word out
interface tdm_demux_1to4_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
);
    logic              in_valid;
    logic              in_sync;
    logic              in_bit;
    logic [NUM_CH-1:0] out;
    logic              out_valid;
    logic [SEL_W-1:0]  sel;
    logic              frame_err;

    modport master (
        output in_valid, in_sync, in_bit,
        input  out, out_valid, sel, frame_err
    );

    modport slave (
        input  in_valid, in_sync, in_bit,
        output out, out_valid, sel, frame_err
    );
endinterface

// File: rtl/tdm_slot_cnt.sv
// rtl/tdm_slot_cnt.sv - loadable wrapping slot counter with terminal-count flag
module tdm_slot_cnt #(
    parameter int             CNT_W = 2,
    parameter logic [CNT_W-1:0] LAST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             restart,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    assign tc = (cnt == LAST);

    // restart loads 1 because the sync bit itself occupies slot 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tdm_demux_1to4.sv
// rtl/tdm_demux_1to4.sv - frame-aligned 1-to-N serial demux with framing error detect
// TDM_PARITY_CHK_EN: frame carries an extra even-parity slot checked before update.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    tdm_demux_1to4_if.slave  bus
);
    localparam int               CNT_W = SEL_W + PAR_SLOTS;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(frame_len(NUM_CH) - 1);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] shadow, shadow_nxt;
    logic [NUM_CH-1:0] out_q, out_nxt;
    logic              valid_q, valid_nxt;
    logic              err_q, err_nxt;
    logic              inc, restart, clear;
    logic [CNT_W-1:0]  cnt;
    logic              tc;
    logic [SEL_W-1:0]  slot;

    assign slot = cnt[SEL_W-1:0];

    tdm_slot_cnt #(
        .CNT_W (CNT_W),
        .LAST  (LAST)
    ) u_slot_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .restart (restart),
        .clear   (clear),
        .cnt     (cnt),
        .tc      (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            shadow  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        out_nxt    = out_q;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        inc        = 1'b0;
        restart    = 1'b0;
        clear      = 1'b0;
        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.in_sync) begin
                        shadow_nxt[0] = bus.in_bit;
                        restart       = 1'b1;
                        state_nxt     = RECV;
                    end
                end
                RECV: begin
                    if (bus.in_sync) begin
                        // sync anywhere but slot 0 aborts the partial frame
                        err_nxt       = (cnt != '0);
                        shadow_nxt[0] = bus.in_bit;
                        restart       = 1'b1;
                    end else if (cnt == '0) begin
                        err_nxt   = 1'b1;
                        clear     = 1'b1;
                        state_nxt = HUNT;
                    end else if (tc) begin
                        clear = 1'b1;
`ifdef TDM_PARITY_CHK_EN
                        if ((^shadow) == bus.in_bit) begin
                            out_nxt   = shadow;
                            valid_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
`else
                        out_nxt   = {bus.in_bit, shadow[NUM_CH-2:0]};
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        shadow_nxt[slot] = bus.in_bit;
                        inc              = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = err_q;
    assign bus.sel       = slot;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb/tb_tdm_demux_1to4.sv - directed vector bench for tdm_demux_1to4 (TDM_PARITY_CHK_EN aware)
module tb_tdm_demux_1to4;
    import tdm_pkg::*;

    typedef struct {
        logic       rst;
        logic       v;
        logic       s;
        logic       b;
        logic [3:0] eo;
        logic       ev;
        logic       ee;
        logic [1:0] es;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    tdm_demux_1to4_if #(.NUM_CH(4), .SEL_W(2)) bus ();

    tdm_demux_1to4 #(.NUM_CH(4), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic b,
                       input logic [3:0] eo, input logic ev, input logic ee, input logic [1:0] es);
        vec_t t;
        t.rst = r; t.v = v; t.s = s; t.b = b;
        t.eo = eo; t.ev = ev; t.ee = ee; t.es = es;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic b);
        rst          = r;
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         pulses;
        int         pcyc[2];
        logic [3:0] pout[2];
        logic       fbits[$];

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_sync = 1'b0; bus.in_bit = 1'b0;

        //   rst v  s  b   out      ov  fe  sel
        add(1, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
`ifndef TDM_PARITY_CHK_EN
        // no sync after reset: stay hunting, silent
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 2'd0);
        // frame 1,0,1,1 continuous
        add(0, 1, 1, 1, 4'b0000, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd3);
        add(0, 1, 0, 1, 4'b1101, 1, 0, 2'd0);
        add(0, 0, 0, 0, 4'b1101, 0, 0, 2'd0);
        // same frame with a 3-cycle gap after slot 1
        add(0, 1, 1, 1, 4'b1101, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 2'd2);
        add(0, 0, 0, 1, 4'b1101, 0, 0, 2'd2);
        add(0, 0, 1, 1, 4'b1101, 0, 0, 2'd2);
        add(0, 0, 0, 0, 4'b1101, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b1101, 0, 0, 2'd3);
        add(0, 1, 0, 1, 4'b1101, 1, 0, 2'd0);
        // early sync at slot 2 restarts with new frame 0,1,1,0
        add(0, 1, 1, 1, 4'b1101, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 2'd2);
        add(0, 1, 1, 0, 4'b1101, 0, 1, 2'd1);
        add(0, 1, 0, 1, 4'b1101, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b1101, 0, 0, 2'd3);
        add(0, 1, 0, 0, 4'b0110, 1, 0, 2'd0);
        // missing sync at slot 0 -> error, back to HUNT, then silent drops
        add(0, 1, 0, 1, 4'b0110, 0, 1, 2'd0);
        add(0, 1, 0, 1, 4'b0110, 0, 0, 2'd0);
        add(0, 1, 0, 0, 4'b0110, 0, 0, 2'd0);
        // back-to-back frames 0,0,0,1 then 1,0,0,0
        add(0, 1, 1, 0, 4'b0110, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b0110, 0, 0, 2'd2);
        add(0, 1, 0, 0, 4'b0110, 0, 0, 2'd3);
        add(0, 1, 0, 1, 4'b1000, 1, 0, 2'd0);
        add(0, 1, 1, 1, 4'b1000, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b1000, 0, 0, 2'd2);
        add(0, 1, 0, 0, 4'b1000, 0, 0, 2'd3);
        add(0, 1, 0, 0, 4'b0001, 1, 0, 2'd0);
        // reset after slot 2 clears everything; partial frame is gone
        add(0, 1, 1, 1, 4'b0001, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b0001, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b0001, 0, 0, 2'd3);
        add(1, 1, 0, 1, 4'b0000, 0, 0, 2'd0);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd0);
`else
        // data 1,0,1,1 with bad parity 0: error, out untouched
        add(0, 1, 1, 1, 4'b0000, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd3);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 0, 1, 2'd0);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
        // same data with parity 1
        add(0, 1, 1, 1, 4'b0000, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 2'd2);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd3);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 2'd0);
        add(0, 1, 0, 1, 4'b1101, 1, 0, 2'd0);
        // sync landing on the parity slot is an early sync
        add(0, 1, 1, 0, 4'b1101, 0, 0, 2'd1);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 2'd2);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 2'd3);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 2'd0);
        add(0, 1, 1, 1, 4'b1101, 0, 1, 2'd1);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].b);
            chk("out",       i, bus.out,                vecs[i].eo);
            chk("out_valid", i, {3'b0, bus.out_valid},  {3'b0, vecs[i].ev});
            chk("frame_err", i, {3'b0, bus.frame_err},  {3'b0, vecs[i].ee});
            chk("sel",       i, {2'b0, bus.sel},        {2'b0, vecs[i].es});
        end

        // back-to-back frames: pulses must be exactly one frame length apart
        drive(1, 0, 0, 0);
        fbits = '{0, 0, 0, 1};
`ifdef TDM_PARITY_CHK_EN
        fbits.push_back(1);
`endif
        fbits.push_back(1); fbits.push_back(0); fbits.push_back(0); fbits.push_back(0);
`ifdef TDM_PARITY_CHK_EN
        fbits.push_back(1);
`endif
        pulses = 0;
        for (int c = 0; c < fbits.size() + 4; c++) begin
            if (c < fbits.size())
                drive(0, 1, (c % DEF_FRAME_LEN) == 0, fbits[c]);
            else
                drive(0, 0, 0, 0);
            if (bus.frame_err) begin
                total++; bad++;
                $display("FAIL b2b_err cycle %0d: got 1 want 0", c);
            end
            if (bus.out_valid) begin
                if (pulses < 2) begin
                    pcyc[pulses] = c;
                    pout[pulses] = bus.out;
                end
                pulses++;
            end
        end
        chk("b2b_pulses", 0, 4'(pulses), 4'd2);
        if (pulses == 2) begin
            chk("b2b_spacing", 0, 4'(pcyc[1] - pcyc[0]), 4'(DEF_FRAME_LEN));
            chk("b2b_first",   0, 4'(pcyc[0]),           4'(DEF_FRAME_LEN - 1));
            chk("b2b_out0",    0, pout[0],               4'b1000);
            chk("b2b_out1",    0, pout[1],               4'b0001);
        end
        chk("b2b_hold", 0, bus.out, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
